// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: sequences one matrix-multiply pass (A load, skewed B feed/drain, array strobes)
module mm_seq_ctrl #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM),
  parameter int RUN_CYC = 3*DIM-2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   host_a_vld,
  output logic                   host_a_rdy,
  input  logic [DIM*BITS_AB-1:0] host_a,
  input  logic                   host_b_vld,
  output logic                   host_b_rdy,
  input  logic [DIM*BITS_AB-1:0] host_b,
  output logic                   memA_WrEn,
  output logic [ROWBITS-1:0]     memA_Arow,
  output logic [DIM*BITS_AB-1:0] memA_Ain,
  output logic                   memA_en,
  output logic                   memB_en,
  output logic [DIM*BITS_AB-1:0] memB_Bin,
  output logic                   sa_clr,
  output logic                   sa_en
);
  localparam int KBITS = $clog2(RUN_CYC);
  localparam logic [ROWBITS-1:0] ROW_LAST = ROWBITS'(DIM-1);
  localparam logic [KBITS-1:0]   K_DIM    = KBITS'(DIM);
  localparam logic [KBITS-1:0]   K_LAST   = KBITS'(RUN_CYC-1);

  typedef enum logic [2:0] {IDLE, CLR, LOADA, RUN, DONE} state_t;

  state_t             r_state, w_next;
  logic [ROWBITS-1:0] r_row, w_row_nxt;
  logic [KBITS-1:0]   r_k, w_k_nxt;
  logic               r_busy, r_done, r_clr, r_sa_en;
  logic               w_feed, w_a_hs, w_b_hs, w_run_en;

  // Handshakes and the enable window: feed phase stalls on B, drain phase always runs
  always_comb begin
    w_feed   = (r_state == RUN) && (r_k < K_DIM);
    w_a_hs   = (r_state == LOADA) && host_a_vld;
    w_b_hs   = w_feed && host_b_vld;
    w_run_en = (r_state == RUN) && (!w_feed || host_b_vld);
  end

  assign host_a_rdy = (r_state == LOADA);
  assign host_b_rdy = w_feed;
  assign memA_WrEn  = w_a_hs;
  assign memA_Arow  = (r_state == LOADA) ? r_row : '0;
  assign memA_Ain   = w_a_hs ? host_a : '0;
  assign memA_en    = w_run_en;
  assign memB_en    = w_run_en;
  assign memB_Bin   = w_b_hs ? host_b : '0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign sa_clr     = r_clr;
  assign sa_en      = r_sa_en;

  // Next state and counter updates
  always_comb begin
    w_next    = r_state;
    w_row_nxt = r_row;
    w_k_nxt   = r_k;
    case (r_state)
      IDLE:  w_next = start ? CLR : IDLE;
      CLR: begin
        w_next    = LOADA;
        w_row_nxt = '0;
        w_k_nxt   = '0;
      end
      LOADA: if (w_a_hs) begin
        w_row_nxt = r_row + 1'b1;
        if (r_row == ROW_LAST) begin
          w_next  = RUN;
          w_k_nxt = '0;
        end
      end
      RUN: if (w_run_en) begin
        w_k_nxt = r_k + 1'b1;
        if (r_k == K_LAST) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, counters and registered strobes; sa_en trails memA_en by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
      r_sa_en <= 1'b0;
    end else begin
      r_state <= w_next;
      r_row   <= w_row_nxt;
      r_k     <= w_k_nxt;
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
      r_clr   <= (w_next == CLR);
      r_sa_en <= w_run_en;
    end
  end
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: scoreboard bench for mm_seq_ctrl with directed passes
module tb_mm_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        host_a_vld = 1'b0, host_b_vld = 1'b0;
  logic [63:0] host_a = '0, host_b = '0;
  logic        busy, done, host_a_rdy, host_b_rdy, memA_WrEn, memA_en, memB_en, sa_clr, sa_en;
  logic [2:0]  memA_Arow;
  logic [63:0] memA_Ain, memB_Bin;

  typedef struct {int c; int r; logic [63:0] d;} ev_t;
  ev_t qa[$], qe[$];
  int  qclr[$], qd[$];
  int  n_vec = 0, n_bad = 0, cyc = 0;
  bit  mon_on = 0, prev_rst = 0, prev_en = 0;

  mm_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .host_a_vld(host_a_vld), .host_a_rdy(host_a_rdy), .host_a(host_a),
    .host_b_vld(host_b_vld), .host_b_rdy(host_b_rdy), .host_b(host_b),
    .memA_WrEn(memA_WrEn), .memA_Arow(memA_Arow), .memA_Ain(memA_Ain),
    .memA_en(memA_en), .memB_en(memB_en), .memB_Bin(memB_Bin),
    .sa_clr(sa_clr), .sa_en(sa_en)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp expected events
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] arow(input int i);
    return 64'h1122334455667788 ^ {8{8'(i*17+1)}};
  endfunction

  function automatic logic [63:0] bcol(input int j);
    return 64'h80F07F0155AA0C3E ^ {8{8'(j*29+3)}};
  endfunction

  // Monitor: pops expected events whenever the DUT presents a strobe
  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      if (sa_clr === 1'b1) begin
        if (qclr.size() == 0) chk("sa_clr_unexp", sa_clr, 0);
        else chk("sa_clr_cyc", cyc, qclr.pop_front());
      end
      if (memA_WrEn === 1'b1) begin
        if (qa.size() == 0) chk("wren_unexp", memA_WrEn, 0);
        else begin
          e = qa.pop_front();
          chk("wren_cyc", cyc, e.c);
          chk("arow", memA_Arow, e.r);
          chk("ain", memA_Ain, e.d);
        end
      end else chk("ain_zero", memA_Ain, 0);
      if (memA_en === 1'b1) begin
        if (qe.size() == 0) chk("en_unexp", memA_en, 0);
        else begin
          e = qe.pop_front();
          chk("en_cyc", cyc, e.c);
          chk("bin", memB_Bin, e.d);
        end
      end
      if (memB_en !== 1'b1) chk("bin_zero", memB_Bin, 0);
      chk("memb_en_eq", memB_en, memA_en);
      chk("wr_en_excl", memA_WrEn & memA_en, 0);
      chk("sa_en", sa_en, prev_rst ? prev_en : 1'b0);
      if (done === 1'b1) begin
        if (qd.size() == 0) chk("done_unexp", done, 0);
        else chk("done_cyc", cyc, qd.pop_front());
      end
    end
    prev_rst = rst_n;
    prev_en  = (memA_en === 1'b1);
  end

  task automatic wait_hs(input bit is_a);
    int t = 0;
    bit hs;
    do begin
      @(negedge clk);
      hs = is_a ? host_a_rdy : host_b_rdy;
      @(posedge clk); #1;
      t++;
    end while (!hs && t < 100);
    if (!hs) chk(is_a ? "a_hs_timeout" : "b_hs_timeout", hs, 1);
  endtask

  task automatic run_pass(input int astall, input int bstall, input bit hold, input int rstk);
    int base, r, f, bc, t;
    ev_t e;
    start = 1'b1;
    @(posedge clk); #1;
    base = cyc - 1;
    if (!hold) start = 1'b0;
    qclr.push_back(base + 1);
    for (int i = 0; i < 8; i++) begin
      e.c = base + 2 + i + ((astall >= 0 && i > astall) ? 3 : 0);
      e.r = i;
      e.d = arow(i);
      qa.push_back(e);
    end
    r = 10 + ((astall >= 0) ? 3 : 0);
    f = 0;
    for (int j = 0; j < 8; j++) begin
      bc = r + j + ((bstall >= 0 && j >= bstall) ? 2 : 0);
      e.c = base + bc; e.r = 0; e.d = bcol(j);
      if (rstk < 0 || j <= rstk) qe.push_back(e);
      f = bc + 1;
    end
    for (int k = 8; k < 22; k++) begin
      e.c = base + f + k - 8; e.r = 0; e.d = '0;
      if (rstk < 0 || k <= rstk) qe.push_back(e);
    end
    if (rstk < 0) qd.push_back(base + f + 14);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (astall >= 0 && i == astall + 1) begin
        host_a_vld = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("astall_wren", memA_WrEn, 0);
          chk("astall_arow", memA_Arow, i);
          @(posedge clk); #1;
        end
      end
      host_a = arow(i);
      host_a_vld = 1'b1;
      wait_hs(1'b1);
    end
    host_a_vld = 1'b0;
    host_a = '0;
    for (int j = 0; j < 8; j++) begin
      if (bstall >= 0 && j == bstall) begin
        host_b_vld = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("bstall_en", {memA_en, memB_en}, 0);
          chk("bstall_bin", memB_Bin, 0);
          chk("bstall_rdy", host_b_rdy, 1);
          @(posedge clk); #1;
        end
      end
      host_b = bcol(j);
      host_b_vld = 1'b1;
      wait_hs(1'b0);
    end
    host_b_vld = 1'b0;
    host_b = '0;
    if (rstk >= 0) begin
      t = 0;
      while (cyc < base + f + rstk - 8 && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_outs", {memA_en, memB_en, host_b_rdy, busy, done}, 0);
      repeat (30) @(negedge clk);
    end else begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (done !== 1'b1 && t < 100);
      chk("done_seen", done, 1);
      @(negedge clk);
      chk("busy_idle", busy, 0);
    end
    chk("qa_left", qa.size(), 0);
    chk("qe_left", qe.size(), 0);
    chk("qclr_left", qclr.size(), 0);
    chk("qd_left", qd.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    mon_on = 1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_outs", {busy, done, sa_en, sa_clr, host_a_rdy, host_b_rdy, memA_WrEn, memA_en, memB_en}, 0);
    end
    rst_n = 1'b1;
    run_pass(-1, -1, 1'b0, -1);
    run_pass(3, -1, 1'b0, -1);
    run_pass(-1, 5, 1'b0, -1);
    run_pass(-1, -1, 1'b1, -1);
    run_pass(-1, -1, 1'b0, -1);
    run_pass(-1, -1, 1'b0, 10);
    run_pass(-1, -1, 1'b0, -1);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end
endmodule
